// File: rtl/z80_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : z80_bus_master
//  Description : Z80 bus initiator. Requests the bus with BUSREQ/BUSACK and
//                runs Z80-style MREQ/RD/WR memory cycles for an internal
//                command/response requester. Pad outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module z80_bus_master #(
  parameter int T_SETUP     = 2,
  parameter int T_STROBE    = 4,
  parameter int T_HOLD      = 2,
  parameter int ACK_TIMEOUT = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_wr,
  input  logic [15:0] i_cmd_addr,
  input  logic [7:0]  i_cmd_wdata,
  input  logic        i_cmd_last,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_busy,
  output logic        o_busreq_n,
  input  logic        i_busack_n,
  output logic [15:0] o_bus_a,
  output logic        o_bus_a_oe,
  output logic [7:0]  o_bus_d_out,
  output logic        o_bus_d_oe,
  input  logic [7:0]  i_bus_d_in,
  output logic        o_bus_mreq_n,
  output logic        o_bus_rd_n,
  output logic        o_bus_wr_n
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_ADDR   = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_OWN    = 3'd5,
    S_REL    = 3'd6
  } state_t;

  // Phase counter covers the longest of the three bus phases.
  localparam int c_PH_MAX = (T_SETUP > T_STROBE) ?
                            ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD) :
                            ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
  localparam int c_PW = (c_PH_MAX > 1) ? $clog2(c_PH_MAX + 1) : 1;
  localparam int c_TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [c_PW-1:0] c_SETUP_LAST  = c_PW'(T_SETUP - 1);
  localparam logic [c_PW-1:0] c_STROBE_LAST = c_PW'(T_STROBE - 1);
  localparam logic [c_PW-1:0] c_HOLD_LAST   = c_PW'(T_HOLD - 1);
  localparam logic [c_PW-1:0] c_PH_SAT      = c_PW'(c_PH_MAX);
  localparam logic [c_TW-1:0] c_TMO_LAST    = c_TW'(ACK_TIMEOUT - 1);
  localparam logic [c_TW-1:0] c_TMO_SAT     = c_TW'(ACK_TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_PW-1:0]   r_ph;
  logic [c_PW-1:0]   w_ph_nxt;
  logic [c_PW-1:0]   w_ph_inc;
  logic [c_TW-1:0]   r_tmo;
  logic [c_TW-1:0]   w_tmo_nxt;
  logic [c_TW-1:0]   w_tmo_inc;

  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [7:0]        r_din_sync [SYNC_STAGES];
  logic              w_ack_s;
  logic [7:0]        w_din_s;

  logic              r_wr;
  logic [15:0]       r_addr;
  logic [7:0]        r_wdata;
  logic              r_last;
  logic              w_f_wr;
  logic [15:0]       w_f_addr;
  logic [7:0]        w_f_wdata;

  logic              w_ready;
  logic              w_accept;

  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [7:0]        r_rsp_rdata;
  logic              w_rsp_valid;
  logic              w_rsp_err;
  logic [7:0]        w_rsp_rdata;

  logic              r_busreq_n, w_busreq_n;
  logic [15:0]       r_bus_a, w_bus_a;
  logic              r_bus_a_oe, w_bus_a_oe;
  logic [7:0]        r_bus_d_out, w_bus_d_out;
  logic              r_bus_d_oe, w_bus_d_oe;
  logic              r_mreq_n, w_mreq_n;
  logic              r_rd_n, w_rd_n;
  logic              r_wr_n, w_wr_n;

  assign w_ack_s   = r_ack_sync[SYNC_STAGES-1];
  assign w_din_s   = r_din_sync[SYNC_STAGES-1];
  assign w_ready   = (r_state == S_IDLE) || (r_state == S_OWN);
  assign w_accept  = i_cmd_valid && w_ready;
  assign w_ph_inc  = (r_ph == c_PH_SAT) ? r_ph : r_ph + c_PW'(1);
  assign w_tmo_inc = (r_tmo == c_TMO_SAT) ? r_tmo : r_tmo + c_TW'(1);

  // Command fields as seen by the next cycle: fresh on accept, held otherwise.
  assign w_f_wr    = w_accept ? i_cmd_wr    : r_wr;
  assign w_f_addr  = w_accept ? i_cmd_addr  : r_addr;
  assign w_f_wdata = w_accept ? i_cmd_wdata : r_wdata;

  // Synchronise the asynchronous BUSACK and data-in pads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) r_din_sync[i] <= 8'h00;
    end else begin
      r_ack_sync    <= {r_ack_sync[SYNC_STAGES-2:0], i_busack_n};
      r_din_sync[0] <= i_bus_d_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_din_sync[i] <= r_din_sync[i-1];
    end
  end

  // Capture command fields on accept; held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_wr    <= i_cmd_wr;
      r_addr  <= i_cmd_addr;
      r_wdata <= i_cmd_wdata;
      r_last  <= i_cmd_last;
    end
  end

  // Next-state, phase/timeout counters and response generation.
  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_tmo_nxt   = r_tmo;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_REQ;
          w_tmo_nxt   = '0;
        end
      end
      S_REQ: begin
        // A grant seen this cycle wins over an expiring timeout.
        if (!w_ack_s) begin
          w_state_nxt = S_ADDR;
          w_ph_nxt    = '0;
        end else if (r_tmo >= c_TMO_LAST) begin
          w_state_nxt = S_IDLE;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
        end else begin
          w_tmo_nxt   = w_tmo_inc;
        end
      end
      S_ADDR: begin
        if (r_ph >= c_SETUP_LAST) begin
          w_state_nxt = S_STROBE;
          w_ph_nxt    = '0;
        end else begin
          w_ph_nxt    = w_ph_inc;
        end
      end
      S_STROBE: begin
        if (r_ph >= c_STROBE_LAST) begin
          w_state_nxt = S_HOLD;
          w_ph_nxt    = '0;
          if (!r_wr) w_rsp_rdata = w_din_s;
        end else begin
          w_ph_nxt    = w_ph_inc;
        end
      end
      S_HOLD: begin
        if (r_ph >= c_HOLD_LAST) begin
          w_state_nxt = r_last ? S_REL : S_OWN;
          w_rsp_valid = 1'b1;
        end else begin
          w_ph_nxt    = w_ph_inc;
        end
      end
      S_OWN: begin
        if (w_accept) begin
          w_state_nxt = S_ADDR;
          w_ph_nxt    = '0;
        end
      end
      S_REL: begin
        if (w_ack_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pad values decoded from the state being entered, so pads track the state.
  always_comb begin
    w_busreq_n  = 1'b1;
    w_bus_a_oe  = 1'b0;
    w_bus_d_oe  = 1'b0;
    w_mreq_n    = 1'b1;
    w_rd_n      = 1'b1;
    w_wr_n      = 1'b1;
    w_bus_a     = r_bus_a;
    w_bus_d_out = r_bus_d_out;
    case (w_state_nxt)
      S_REQ: w_busreq_n = 1'b0;
      S_ADDR, S_STROBE, S_HOLD: begin
        w_busreq_n = 1'b0;
        w_bus_a_oe = 1'b1;
        w_bus_a    = w_f_addr;
        if (w_f_wr) begin
          w_bus_d_oe  = 1'b1;
          w_bus_d_out = w_f_wdata;
        end
        if (w_state_nxt == S_STROBE) begin
          w_mreq_n = 1'b0;
          w_rd_n   = w_f_wr;
          w_wr_n   = !w_f_wr;
        end
      end
      S_OWN: begin
        w_busreq_n = 1'b0;
        w_bus_a_oe = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counters, response and pad registers; reset releases the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ph        <= '0;
      r_tmo       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_busreq_n  <= 1'b1;
      r_bus_a     <= 16'h0000;
      r_bus_a_oe  <= 1'b0;
      r_bus_d_out <= 8'h00;
      r_bus_d_oe  <= 1'b0;
      r_mreq_n    <= 1'b1;
      r_rd_n      <= 1'b1;
      r_wr_n      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_ph        <= w_ph_nxt;
      r_tmo       <= w_tmo_nxt;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
      r_busreq_n  <= w_busreq_n;
      r_bus_a     <= w_bus_a;
      r_bus_a_oe  <= w_bus_a_oe;
      r_bus_d_out <= w_bus_d_out;
      r_bus_d_oe  <= w_bus_d_oe;
      r_mreq_n    <= w_mreq_n;
      r_rd_n      <= w_rd_n;
      r_wr_n      <= w_wr_n;
    end
  end

  assign o_cmd_ready  = w_ready;
  assign o_busy       = (r_state != S_IDLE);
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_err    = r_rsp_err;
  assign o_rsp_rdata  = r_rsp_rdata;
  assign o_busreq_n   = r_busreq_n;
  assign o_bus_a      = r_bus_a;
  assign o_bus_a_oe   = r_bus_a_oe;
  assign o_bus_d_out  = r_bus_d_out;
  assign o_bus_d_oe   = r_bus_d_oe;
  assign o_bus_mreq_n = r_mreq_n;
  assign o_bus_rd_n   = r_rd_n;
  assign o_bus_wr_n   = r_wr_n;

endmodule
`default_nettype wire
